// File: rtl/display_pkg.sv
// Shared display definitions: VGA timing defaults, the RGB444 pixel type,
// frame-buffer geometry helpers and the bank-swap FSM encoding.
package display_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int SCALE_DEF    = 4;
  localparam int ADDR_W_DEF   = 16;

  // RGB444 pixel as stored in the frame buffer.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  localparam int PIXEL_W_DEF = $bits(pixel_t);

  // Stored-buffer dimension for a given visible size; SCALE is a power of two.
  function automatic int fb_dim(input int active, input int scale);
    return active >> $clog2(scale);
  endfunction

  localparam int FB_W_DEF     = fb_dim(H_ACTIVE_DEF, SCALE_DEF);
  localparam int FB_H_DEF     = fb_dim(V_ACTIVE_DEF, SCALE_DEF);
  localparam int FB_DEPTH_DEF = FB_W_DEF * FB_H_DEF;

  typedef enum logic {
    SWAP_IDLE = 1'b0,
    SWAP_ACK  = 1'b1
  } swap_state_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Frame-buffer read port plus the bank-swap handshake with the writer.
interface vga_scanout_if #(
  parameter int ADDR_W  = 16,
  parameter int PIXEL_W = 12
);
  logic               rd_en;
  logic [ADDR_W:0]    rd_addr;
  logic [PIXEL_W-1:0] rd_data;
  logic               swap_req;
  logic               swap_ack;
  logic               front_sel;

  // Scanout side.
  modport master (
    output rd_en, rd_addr, swap_ack, front_sel,
    input  rd_data, swap_req
  );

  // Buffer / writer side.
  modport slave (
    input  rd_en, rd_addr, swap_ack, front_sel,
    output rd_data, swap_req
  );
endinterface

// File: rtl/vga_timing.sv
// Raster counters with raw (undelayed) sync, active and frame-start flags.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_h_wrap,
  output logic          o_v_last,
  output logic          o_active,
  output logic          o_hsync_n,
  output logic          o_vsync_n,
  output logic          o_frame_start
);
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_wrap;
  logic          w_v_last;

  assign w_h_wrap = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));

  // Advance h every clock, v on each line wrap, both wrapping to zero.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_h_wrap      = w_h_wrap;
  assign o_v_last      = w_v_last;
  assign o_active      = (32'(r_h_cnt) < H_ACTIVE) && (32'(r_v_cnt) < V_ACTIVE);
  assign o_hsync_n     = !((32'(r_h_cnt) >= H_SYNC_START) && (32'(r_h_cnt) < H_SYNC_START + H_SYNC));
  assign o_vsync_n     = !((32'(r_v_cnt) >= V_SYNC_START) && (32'(r_v_cnt) < V_SYNC_START + V_SYNC));
  assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/vga_scanout.sv
// Front-bank reader: upscaled raster addressing, vblank-only bank swap and
// a two-stage pipeline that aligns syncs/de with the returned pixel.
module vga_scanout
  import display_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SCALE    = SCALE_DEF,
  parameter int PIXEL_W  = PIXEL_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  vga_scanout_if.master      fb,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [PIXEL_W-1:0] rgb
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int SCALE_SH = $clog2(SCALE);
  localparam int FB_W     = fb_dim(H_ACTIVE, SCALE);

  logic [HW-1:0]     w_h_cnt;
  logic [VW-1:0]     w_v_cnt;
  logic              w_h_wrap, w_v_last, w_active, w_hsync_n, w_vsync_n;
  logic              w_row_last, w_vblank_entry, w_swap;
  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W:0]   w_addr;
  swap_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W:0]   r_last_addr;
  logic              r_front_sel;
  logic              r_de1, r_hs1, r_vs1;
  logic              r_de, r_hs, r_vs;
  logic [PIXEL_W-1:0] r_rgb;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .o_h_cnt      (w_h_cnt),
    .o_v_cnt      (w_v_cnt),
    .o_h_wrap     (w_h_wrap),
    .o_v_last     (w_v_last),
    .o_active     (w_active),
    .o_hsync_n    (w_hsync_n),
    .o_vsync_n    (w_vsync_n),
    .o_frame_start(frame_start)
  );

  // The next line begins a new stored row when (v+1) is a multiple of SCALE.
  assign w_row_last     = (((32'(w_v_cnt) + 32'd1) % 32'(SCALE)) == 32'd0);
  assign w_vblank_entry = (w_h_cnt == '0) && (32'(w_v_cnt) == V_ACTIVE);
  assign w_col          = ADDR_W'(w_h_cnt >> SCALE_SH);
  assign w_addr         = {r_front_sel, r_line_base + w_col};

  // Track (v/SCALE)*FB_W incrementally instead of multiplying.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line_base <= '0;
    end else if (w_h_wrap) begin
      if (w_v_last)        r_line_base <= '0;
      else if (w_row_last) r_line_base <= r_line_base + ADDR_W'(FB_W);
    end
  end

  // Remember the last active address so rd_addr is quiet during blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last_addr <= '0;
    else if (w_active) r_last_addr <= w_addr;
  end

  assign fb.rd_en   = w_active;
  assign fb.rd_addr = w_active ? w_addr : r_last_addr;

  // Swap FSM state register and front-bank toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SWAP_IDLE;
      r_front_sel <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_swap) r_front_sel <= ~r_front_sel;
    end
  end

  // Swap FSM next state: exchange banks only on entry to vertical blanking.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      SWAP_IDLE: begin
        if (w_vblank_entry && fb.swap_req) begin
          w_state_nxt = SWAP_ACK;
          w_swap      = 1'b1;
        end
      end
      SWAP_ACK:  w_state_nxt = SWAP_IDLE;
      default:   w_state_nxt = SWAP_IDLE;
    endcase
  end

  assign fb.swap_ack  = (r_state == SWAP_ACK);
  assign fb.front_sel = r_front_sel;

  // Delay de/syncs two clocks and register the returned pixel alongside them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_de1 <= 1'b0;
      r_hs1 <= 1'b1;
      r_vs1 <= 1'b1;
      r_de  <= 1'b0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_rgb <= '0;
    end else begin
      r_de1 <= w_active;
      r_hs1 <= w_hsync_n;
      r_vs1 <= w_vsync_n;
      r_de  <= r_de1;
      r_hs  <= r_hs1;
      r_vs  <= r_vs1;
      r_rgb <= r_de1 ? fb.rd_data : '0;
    end
  end

  assign de    = r_de;
  assign hsync = r_hs;
  assign vsync = r_vs;
  assign rgb   = r_rgb;

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side reader of the lava-lamp frame buffer. The metaball renderer writes frames into a double-banked buffer; this block reads the front bank in raster order, upscales each stored pixel by `SCALE`, and produces VGA timing (hsync/vsync/de) with pixel data aligned to it. It also owns the bank-swap handshake with the writer, so a bank is only exchanged during vertical blanking.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal porch and sync widths, in clocks
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical porch and sync widths, in lines
- `SCALE`, 4: upscale factor, power of two. The buffer holds `H_ACTIVE/SCALE` × `V_ACTIVE/SCALE` pixels.
- `PIXEL_W`, 12: pixel width, RGB444
- `ADDR_W`, 16: bank-local address width; must be ≥ clog2(FB_W·FB_H)

Ports:
- `clk`, in, 1: pixel clock
- `rst`, in, 1: asynchronous, active-high reset
- `rd_en`, out, 1: buffer read strobe
- `rd_addr`, out, `ADDR_W+1`: read address; MSB = front bank
- `rd_data`, in, `PIXEL_W`: read data, valid exactly one cycle after `rd_en`
- `swap_req`, in, 1: level; the writer has finished the back bank
- `swap_ack`, out, 1: one-cycle pulse when the banks have been exchanged
- `front_sel`, out, 1: bank currently being displayed
- `frame_start`, out, 1: one-cycle pulse when the counters are at (0,0)
- `hsync`, `vsync`, out, 1 each: active-low sync
- `de`, out, 1: data enable (active video)
- `rgb`, out, `PIXEL_W`: pixel out; 0 when `de`=0

## Operation
- Counters `h_cnt` run 0..H_TOTAL−1 and `v_cnt` run 0..V_TOTAL−1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, similarly V_TOTAL). `h_cnt` wraps every cycle it reaches H_TOTAL−1; `v_cnt` advances on that wrap and itself wraps at V_TOTAL−1 to 0.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. Sync is asserted (low) while h_cnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync uses the same rule on `v_cnt`.
- Address generation uses no multiplier:
  - `line_base` is the register tracking (v_cnt/SCALE)·FB_W. It resets to 0 at v_cnt wrap and gains FB_W at each line wrap where (v_cnt+1) mod SCALE = 0.
  - rd_addr = {front_sel, line_base + h_cnt>>log2(SCALE)}.
- `rd_en` = active region, driven combinationally from counter state. Outside the active region `rd_addr` holds its last value.
- Swap FSM has states IDLE and ACK:
  - IDLE→ACK on the cycle h_cnt=0, v_cnt=V_ACTIVE (first blanking line) if `swap_req`=1. On that edge `front_sel` toggles.
  - ACK drives `swap_ack`=1 for one cycle, then returns to IDLE unconditionally.
  - A `swap_req` arriving at any other time waits for the next vblank entry.
  - If `swap_req` is still high after an ack, it swaps again at the next vblank; the writer must drop the request on the ack.
- `front_sel` never changes while v_cnt < V_ACTIVE.

## Timing
- Two-stage pipeline:
  - Cycle N: counters drive `rd_en`/`rd_addr`.
  - Cycle N+1: `rd_data` is valid.
  - Edge ending N+1: `rgb`, `de`, `hsync`, `vsync` are registered, so they are visible in N+2.
  - Syncs and `de` are delayed 2 cycles so they stay aligned with `rgb`.
- `frame_start` is combinational from the counters (h=0, v=0), so it leads the pin-side pixel (0,0) by 2 cycles.
- Reset values: counters 0, `line_base` 0, `front_sel` 0, FSM IDLE, `swap_ack` 0, `de` 0, `rgb` 0, `hsync`/`vsync` 1, pipeline registers cleared. `rd_en`/`frame_start` follow the counters, so both are 1 after reset.
- Reset mid-frame restarts scanout at (0,0) on the first edge after release. Any pending swap is dropped and `front_sel` returns to 0.

## Structure
- Shared package `display_pkg`: VGA timing defaults, the `pixel_t` typedef (RGB444), and a `clog2`-derived FB_W/FB_H/FB_DEPTH.
- One natural sub-module, `vga_timing`: the counters plus raw sync/active/frame_start. `vga_scanout` adds address generation, the swap FSM and the alignment pipeline.

## Test plan
Benches use reduced timing: H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1. The buffer model has 1-cycle latency and data = address.
- SCALE=1, free-run two frames → `hsync` low 2 clocks per 12-clock line; `vsync` low for one 12-clock line; 32 `de` cycles per frame; `rgb` = address 0..31 in order.
- SCALE=2 → each fetched address repeats 2 clocks and 2 lines; row 0 reads 0,0,1,1,2,2,3,3 twice, then row 1 reads 4..7.
- Hold `swap_req` mid-frame → no toggle until the cycle h=0, v=4; then `front_sel`=1, a single `swap_ack`, and next frame `rd_addr` MSB = 1.
- `swap_req` held across two vblanks → two acks and `front_sel` back to 0.
- Assert `rst` at h=5, v=2 for 3 cycles → outputs take reset values immediately (async); the first `de` comes 2 cycles after release, with `rgb`=0 at address 0.
- Check `rgb`=0 whenever `de`=0, and `de` rising exactly 2 cycles after `frame_start`.
